// File: rtl/redun_mont_pkg.sv
`default_nettype none
// ============================================================================
// Package : redun_mont_pkg
// Brief   : Shared sizing constants and FSM state type for the redundant
//           carry normalizer and its carry-propagation step.
// Revision: 1.0  initial release
// ============================================================================
package redun_mont_pkg;

  // Default geometry of the multiplier output bank.
  localparam int DEF_NUM_ELEMENTS = 33;
  localparam int DEF_DSP_BIT_LEN  = 17;
  localparam int DEF_WORD_LEN     = 16;

  // Derived sizes. A redundant coefficient plus the incoming carry fits in
  // DSP_BIT_LEN+1 bits, so the carry out of a step needs
  // DSP_BIT_LEN-WORD_LEN+1 bits and can never overflow that width.
  localparam int CARRY_W   = DEF_DSP_BIT_LEN - DEF_WORD_LEN + 1;
  localparam int NUM_WORDS = 2 * DEF_NUM_ELEMENTS;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  // Normalizer control states.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage : redun_mont_pkg
`default_nettype wire

// File: rtl/carry_prop_step.sv
`default_nettype none
// ============================================================================
// Module  : carry_prop_step
// Brief   : One combinational carry-propagation step. Adds the running carry
//           to a redundant coefficient, returning the canonical low word and
//           the carry into the next, more significant coefficient.
// Revision: 1.0  initial release
// ============================================================================
module carry_prop_step
  import redun_mont_pkg::*;
#(
  parameter int DSP_BIT_LEN = DEF_DSP_BIT_LEN,
  parameter int WORD_LEN    = DEF_WORD_LEN
) (
  input  logic [DSP_BIT_LEN-1:0]          i_coef,
  input  logic [DSP_BIT_LEN-WORD_LEN:0]   i_carry,
  output logic [WORD_LEN-1:0]             o_word,
  output logic [DSP_BIT_LEN-WORD_LEN:0]   o_carry_next
);

  localparam int CW = DSP_BIT_LEN - WORD_LEN + 1;

  // One extra bit holds the full coefficient-plus-carry sum.
  logic [DSP_BIT_LEN:0] w_sum;

  assign w_sum        = {1'b0, i_coef} + {{(DSP_BIT_LEN + 1 - CW){1'b0}}, i_carry};
  assign o_word       = w_sum[WORD_LEN-1:0];
  assign o_carry_next = w_sum[DSP_BIT_LEN:WORD_LEN];

endmodule : carry_prop_step
`default_nettype wire

// File: rtl/redundant_carry_normalizer.sv
`default_nettype none
// ============================================================================
// Module  : redundant_carry_normalizer
// Brief   : Captures a bank of redundant multiplier coefficients and streams
//           them out LSW first as canonical words over valid/ready, resolving
//           one carry per accepted word. The final carry-out rides with the
//           last word.
// Revision: 1.0  initial release
// ============================================================================
module redundant_carry_normalizer
  import redun_mont_pkg::*;
#(
  parameter int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
  parameter int DSP_BIT_LEN  = DEF_DSP_BIT_LEN,
  parameter int WORD_LEN     = DEF_WORD_LEN
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  // Bank input
  input  logic                                          i_val,
  output logic                                          o_rdy,
  input  logic [2*NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    i_dat,
  // Word stream output
  output logic                                          o_val,
  input  logic                                          i_rdy,
  output logic [WORD_LEN-1:0]                           o_word,
  output logic [$clog2(2*NUM_ELEMENTS)-1:0]             o_idx,
  output logic                                          o_sop,
  output logic                                          o_eop,
  output logic [DSP_BIT_LEN-WORD_LEN:0]                 o_carry
);

  localparam int NW = 2 * NUM_ELEMENTS;
  localparam int IW = $clog2(NW);
  localparam int CW = DSP_BIT_LEN - WORD_LEN + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                             state_q, state_d;
  logic [NW-1:0][DSP_BIT_LEN-1:0]     bank_q,  bank_d;
  logic [IW-1:0]                      idx_q,   idx_d;
  // Carry out of the step currently presented on o_word; it is the carry-in
  // of the next step to be loaded.
  logic [CW-1:0]                      carry_q, carry_d;
  logic [WORD_LEN-1:0]                word_q,  word_d;
  logic                               sop_q,   sop_d;
  logic                               eop_q,   eop_d;
  logic [CW-1:0]                      ocarry_q, ocarry_d;

  // Step datapath
  logic [DSP_BIT_LEN-1:0]             w_coef;
  logic [CW-1:0]                      w_cin;
  logic [WORD_LEN-1:0]                w_step_word;
  logic [CW-1:0]                      w_step_carry;
  logic [IW-1:0]                      w_idx_nxt;
  logic                               w_nxt_is_last;

  // Next index wraps to 0 on the last word so the bank select never leaves
  // the valid coefficient range; the wrapped value is never loaded.
  assign w_idx_nxt     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  assign w_nxt_is_last = (w_idx_nxt == LAST_IDX);

  // Single shared carry step: fed from the input port while idle (step 0),
  // from the captured bank while streaming (step idx+1).
  carry_prop_step #(
    .DSP_BIT_LEN (DSP_BIT_LEN),
    .WORD_LEN    (WORD_LEN)
  ) u_step (
    .i_coef       (w_coef),
    .i_carry      (w_cin),
    .o_word       (w_step_word),
    .o_carry_next (w_step_carry)
  );

  // Next-state, operand selection and output-register load decisions.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    word_d   = word_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    ocarry_d = ocarry_q;
    w_coef   = i_dat[0];
    w_cin    = '0;

    case (state_q)
      IDLE: begin
        w_coef = i_dat[0];
        w_cin  = '0;
        if (i_val) begin
          bank_d   = i_dat;
          idx_d    = '0;
          word_d   = w_step_word;
          carry_d  = w_step_carry;
          sop_d    = 1'b1;
          eop_d    = (LAST_IDX == '0);
          ocarry_d = (LAST_IDX == '0) ? w_step_carry : '0;
          state_d  = STREAM;
        end
      end

      STREAM: begin
        w_coef = bank_q[w_idx_nxt];
        w_cin  = carry_q;
        // o_val is high throughout STREAM, so i_rdy alone is the handshake.
        if (i_rdy) begin
          if (eop_q) begin
            state_d = IDLE;
          end else begin
            idx_d    = w_idx_nxt;
            word_d   = w_step_word;
            carry_d  = w_step_carry;
            sop_d    = 1'b0;
            eop_d    = w_nxt_is_last;
            ocarry_d = w_nxt_is_last ? w_step_carry : '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, bank and output registers; reset discards any bank in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      bank_q   <= '0;
      idx_q    <= '0;
      carry_q  <= '0;
      word_q   <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      ocarry_q <= '0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      word_q   <= word_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      ocarry_q <= ocarry_d;
    end
  end

  assign o_rdy   = (state_q == IDLE);
  assign o_val   = (state_q == STREAM);
  assign o_word  = word_q;
  assign o_idx   = idx_q;
  assign o_sop   = sop_q;
  assign o_eop   = eop_q;
  assign o_carry = ocarry_q;

endmodule : redundant_carry_normalizer
`default_nettype wire

// File: tb/tb_redundant_carry_normalizer.sv
`default_nettype none
// ============================================================================
// Module  : tb_redundant_carry_normalizer
// Brief   : Self-checking bench for redundant_carry_normalizer: directed
//           vector table, random banks against a bignum model, back-to-back
//           banks and reset in mid-bank.
// Revision: 1.0  initial release
// ============================================================================
module tb_redundant_carry_normalizer;

  typedef logic [16:0] bank_t  [66];
  typedef logic [15:0] words_t [66];

  typedef struct {
    logic [16:0] c0;     // coefficient 0
    logic [16:0] crest;  // coefficients 1..65
    logic [15:0] w0;     // expected word 0
    logic [15:0] w1;     // expected word 1
    logic [15:0] wrest;  // expected words 2..65
    logic [1:0]  carry;  // expected final carry
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_val;
  logic                 o_rdy;
  logic [65:0][16:0]    i_dat;
  logic                 o_val;
  logic                 i_rdy;
  logic [15:0]          o_word;
  logic [6:0]           o_idx;
  logic                 o_sop;
  logic                 o_eop;
  logic [1:0]           o_carry;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  redundant_carry_normalizer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_val   (i_val),
    .o_rdy   (o_rdy),
    .i_dat   (i_dat),
    .o_val   (o_val),
    .i_rdy   (i_rdy),
    .o_word  (o_word),
    .o_idx   (o_idx),
    .o_sop   (o_sop),
    .o_eop   (o_eop),
    .o_carry (o_carry)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bank value = sum of coef[k] * 2^(16k); normalise it as a plain bignum
  // of 16-bit limbs, limb 66 holding whatever lies above the last word.
  function automatic void model(input bank_t b, output words_t w, output logic [1:0] c);
    longint r [67];
    longint acc;
    int     j;
    for (int i = 0; i < 67; i++) r[i] = 0;
    for (int k = 0; k < 66; k++) begin
      acc = longint'(b[k]);
      j   = k;
      while (acc != 0) begin
        r[j] += acc;
        if (j == 66) begin
          acc = 0;
        end else begin
          acc  = r[j] >> 16;
          r[j] = r[j] & 64'hFFFF;
        end
        j++;
      end
    end
    for (int i = 0; i < 66; i++) w[i] = r[i][15:0];
    c = r[66][1:0];
  endfunction

  task automatic drive_bank(input bank_t b);
    for (int i = 0; i < 66; i++) i_dat[i] = b[i];
  endtask

  // Present a bank and return just after the edge that captures it.
  task automatic start(input bank_t b);
    int t;
    @(negedge clk);
    drive_bank(b);
    i_val = 1'b1;
    t = 0;
    while (!o_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_rdy) chk("capture_wait", o_rdy, 1);
    @(posedge clk);
  endtask

  // Consume one bank starting right after its capture edge. Returns just
  // after the eop handshake edge. i_val/i_dat are set to hold_val/nxt on
  // the first cycle.
  task automatic collect(input words_t ew, input logic [1:0] ec, input int stall_pct,
                         input bit hold_val, input bank_t nxt, output int eop_cyc);
    int          n;
    int          cyc;
    bit          stalled;
    bit          hs;
    logic [15:0] pw;
    logic [6:0]  pi;
    n       = 0;
    cyc     = 1;
    stalled = 1'b0;
    pw      = '0;
    pi      = '0;
    eop_cyc = -1;
    while (n < 66 && cyc < 2000) begin
      @(negedge clk);
      if (cyc == 1) begin
        i_val = hold_val;
        drive_bank(nxt);
      end
      chk("o_val_in_stream", o_val, 1);
      if (o_val) begin
        chk("word", {o_rdy, o_idx, o_sop, o_eop, o_carry, o_word},
            {1'b0, 7'(n), (n == 0), (n == 65), ((n == 65) ? ec : 2'b00), ew[n]});
        if (stalled) chk("stall_hold", {o_idx, o_word}, {pi, pw});
        if (o_eop) eop_cyc = cyc;
      end
      i_rdy   = ($urandom_range(99) >= stall_pct);
      hs      = o_val && i_rdy;
      stalled = o_val && !i_rdy;
      pw      = o_word;
      pi      = o_idx;
      @(posedge clk);
      if (hs) n++;
      cyc++;
    end
    if (n < 66) chk("bank_timeout", n, 66);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   tbl [3];
    bank_t  ba, bb;
    words_t ewa, ewb;
    logic [1:0] ca, cb;
    int     ec;
    int     t;

    rst_n = 1'b0;
    i_val = 1'b0;
    i_rdy = 1'b0;
    i_dat = '0;

    // 0x1FFFF + 1 gives word 0 / carry 2, then 0x1FFFF + 2 gives word 1 /
    // carry 2 for every remaining step.
    tbl[0] = '{17'h0FFFF, 17'h0FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'd0};
    tbl[1] = '{17'h1FFFF, 17'h0FFFF, 16'hFFFF, 16'h0000, 16'h0000, 2'd1};
    tbl[2] = '{17'h1FFFF, 17'h1FFFF, 16'hFFFF, 16'h0000, 16'h0001, 2'd2};

    repeat (3) @(negedge clk);
    chk("reset_state", {o_rdy, o_val, o_word, o_idx, o_sop, o_eop, o_carry},
        {1'b1, 1'b0, 16'h0, 7'h0, 1'b0, 1'b0, 2'b0});
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_release", {o_rdy, o_val}, 2'b10);

    // Directed vectors, i_rdy held high.
    for (int v = 0; v < 3; v++) begin
      ba[0] = tbl[v].c0;
      for (int k = 1; k < 66; k++) ba[k] = tbl[v].crest;
      ewa[0] = tbl[v].w0;
      ewa[1] = tbl[v].w1;
      for (int k = 2; k < 66; k++) ewa[k] = tbl[v].wrest;
      start(ba);
      collect(ewa, tbl[v].carry, 0, 1'b0, ba, ec);
      chk("eop_cycle", ec, 66);
    end

    // Random banks with ~30% backpressure.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 66; k++)
        ba[k] = (r >= 3) ? 17'($urandom_range(17'h1FFF0, 17'h1FFFF))
                         : 17'($urandom_range(0, 17'h1FFFF));
      model(ba, ewa, ca);
      start(ba);
      collect(ewa, ca, 30, 1'b0, ba, ec);
    end

    // Back-to-back banks with i_val held high.
    for (int k = 0; k < 66; k++) begin
      ba[k] = 17'($urandom_range(0, 17'h1FFFF));
      bb[k] = 17'($urandom_range(0, 17'h1FFFF));
    end
    model(ba, ewa, ca);
    model(bb, ewb, cb);
    start(ba);
    collect(ewa, ca, 0, 1'b1, bb, ec);
    @(negedge clk);
    chk("gap_cycle", {o_rdy, o_val}, 2'b10);
    @(posedge clk);
    collect(ewb, cb, 0, 1'b0, bb, ec);

    // Reset asserted while word 20 is on the output.
    start(ba);
    t = 0;
    while (t < 200) begin
      @(negedge clk);
      i_val = 1'b0;
      i_rdy = 1'b1;
      if (o_val && o_idx == 7'd20) break;
      t++;
    end
    chk("reach_idx20", o_idx, 20);
    rst_n = 1'b0;
    #1;
    chk("reset_async", {o_rdy, o_val}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_reset_idle", {o_rdy, o_val}, 2'b10);
    end
    model(bb, ewb, cb);
    start(bb);
    collect(ewb, cb, 30, 1'b0, bb, ec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_redundant_carry_normalizer
`default_nettype wire
